// File: rtl/synth_pkg.sv
// Shared definitions for the synth datapath: DAC frame geometry, config nibble
// and the SPI DAC transmitter state encoding.
package synth_pkg;

    localparam int unsigned DAC_FRAME_W = 16;
    localparam int unsigned DAC_DATA_W  = 12;
    localparam int unsigned DAC_CFG_W   = DAC_FRAME_W - DAC_DATA_W;
    localparam int unsigned DAC_BIT_W   = $clog2(DAC_FRAME_W);

    // A/B=0, BUF=0, GA_n=1, SHDN_n=1
    localparam logic [DAC_CFG_W-1:0] DAC_CFG_DEFAULT = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_LATCH = 2'd3
    } dac_state_t;

    typedef struct packed {
        logic [DAC_CFG_W-1:0]  cfg;
        logic [DAC_DATA_W-1:0] data;
    } dac_frame_t;

endpackage

// File: rtl/dac_clk_div.sv
// SCK phase divider: one-cycle tick every DIV clk cycles while enabled.
module dac_clk_div #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick,
    output logic pre_tick_c
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

    // High when the edge after the coming one will carry a tick.
    generate
        if (DIV == 1) begin : g_div1
            assign pre_tick_c = 1'b1;
        end else begin : g_divn
            assign pre_tick_c = (cnt == CW'(DIV - 2));
        end
    endgenerate

endmodule

// File: rtl/spi_dac_tx.sv
// Serial transmitter for an MCP4921-style 12-bit SPI DAC: takes one modulated
// sample per frame over valid/ready and drives CS/SCK/SDI/LDAC (SPI mode 0).
module spi_dac_tx
    import synth_pkg::*;
#(
    parameter int unsigned          O      = 16,
    parameter int unsigned          CLKDIV = 4,
    parameter logic [DAC_CFG_W-1:0] CFG    = DAC_CFG_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [O-1:0] sampleIn,
    input  logic         sampleValid,
    output logic         sampleReady,
    output logic         dacCs_n,
    output logic         dacSck,
    output logic         dacSdi,
    output logic         dacLdac_n,
    output logic         busy
);

    dac_state_t             state;
    logic [DAC_FRAME_W-1:0] frame;
    logic [DAC_BIT_W-1:0]   bit_cnt;
    logic                   tick;
    logic                   pre_tick_c;
    logic                   accept_c;
    logic                   ready_next_c;
    dac_frame_t             load_c;

    dac_clk_div #(
        .DIV(CLKDIV)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .en        (state != ST_IDLE),
        .tick      (tick),
        .pre_tick_c(pre_tick_c)
    );

    // Truncate the sample to the DAC resolution; low bits are dropped.
    assign load_c.cfg  = CFG;
    assign load_c.data = sampleIn[O-1 -: DAC_DATA_W];

    generate
        if (O > DAC_DATA_W) begin : g_trunc
            logic unused_lsbs;
            assign unused_lsbs = ^sampleIn[O-DAC_DATA_W-1:0];
        end
    endgenerate

    assign accept_c = sampleValid && sampleReady;

    // Ready also rises for the final LATCH cycle so a held valid is taken on the
    // LATCH-ending edge and frames run back to back every 34*CLKDIV cycles.
    always_comb begin
        ready_next_c = 1'b0;
        if ((state == ST_IDLE) && !accept_c) begin
            ready_next_c = 1'b1;
        end else if ((state == ST_LATCH) && tick && !accept_c) begin
            ready_next_c = 1'b1;
        end else if (((state == ST_LATCH) && !tick) || ((state == ST_HOLD) && tick)) begin
            ready_next_c = pre_tick_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            frame       <= '0;
            bit_cnt     <= '0;
            sampleReady <= 1'b1;
            busy        <= 1'b0;
            dacCs_n     <= 1'b1;
            dacSck      <= 1'b0;
            dacSdi      <= 1'b0;
            dacLdac_n   <= 1'b1;
        end else begin
            sampleReady <= ready_next_c;
            busy        <= ~ready_next_c;
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        state   <= ST_SHIFT;
                        frame   <= load_c;
                        bit_cnt <= DAC_BIT_W'(DAC_FRAME_W - 1);
                        dacCs_n <= 1'b0;
                        dacSck  <= 1'b0;
                        dacSdi  <= load_c.cfg[DAC_CFG_W-1];
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        if (!dacSck) begin
                            dacSck <= 1'b1;
                        end else if (bit_cnt == '0) begin
                            state  <= ST_HOLD;
                            dacSck <= 1'b0;
                            dacSdi <= 1'b0;
                        end else begin
                            dacSck  <= 1'b0;
                            bit_cnt <= bit_cnt - DAC_BIT_W'(1);
                            frame   <= {frame[DAC_FRAME_W-2:0], 1'b0};
                            dacSdi  <= frame[DAC_FRAME_W-2];
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        state     <= ST_LATCH;
                        dacCs_n   <= 1'b1;
                        dacLdac_n <= 1'b0;
                    end
                end
                ST_LATCH: begin
                    if (tick) begin
                        dacLdac_n <= 1'b1;
                        if (accept_c) begin
                            state   <= ST_SHIFT;
                            frame   <= load_c;
                            bit_cnt <= DAC_BIT_W'(DAC_FRAME_W - 1);
                            dacCs_n <= 1'b0;
                            dacSck  <= 1'b0;
                            dacSdi  <= load_c.cfg[DAC_CFG_W-1];
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_dac_tx.sv
// Bench for spi_dac_tx: directed samples into a CLKDIV=4 and a CLKDIV=1 instance,
// frames reassembled from SCK/SDI and checked against a queue of expected words.
module tb_spi_dac_tx;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          abort_pending = 1'b0;

    logic        a_rst, a_valid, a_ready, a_cs, a_sck, a_sdi, a_ldac, a_busy;
    logic [15:0] a_in;
    logic        b_rst, b_valid, b_ready, b_cs, b_sck, b_sdi, b_ldac, b_busy;
    logic [15:0] b_in;

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_dac_tx #(.O(16), .CLKDIV(4)) dut_a (
        .clk(clk), .rst(a_rst), .sampleIn(a_in), .sampleValid(a_valid),
        .sampleReady(a_ready), .dacCs_n(a_cs), .dacSck(a_sck), .dacSdi(a_sdi),
        .dacLdac_n(a_ldac), .busy(a_busy)
    );

    spi_dac_tx #(.O(16), .CLKDIV(1)) dut_b (
        .clk(clk), .rst(b_rst), .sampleIn(b_in), .sampleValid(b_valid),
        .sampleReady(b_ready), .dacCs_n(b_cs), .dacSck(b_sck), .dacSdi(b_sdi),
        .dacLdac_n(b_ldac), .busy(b_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: rebuild each frame from SDI at SCK rising edges, compare at CS rise.
    initial begin
        logic [15:0] sh[2];
        int          nb[2];
        bit          inf[2];
        logic        pcs[2], psck[2];
        logic        cs_s, sck_s, sdi_s;
        logic [15:0] expv;
        bit          empty;
        for (int i = 0; i < 2; i++) begin
            sh[i] = '0; nb[i] = 0; inf[i] = 1'b0; pcs[i] = 1'b1; psck[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                cs_s  = (i == 0) ? a_cs  : b_cs;
                sck_s = (i == 0) ? a_sck : b_sck;
                sdi_s = (i == 0) ? a_sdi : b_sdi;
                if (!cs_s && pcs[i]) begin
                    inf[i] = 1'b1; nb[i] = 0; sh[i] = '0;
                end
                if (inf[i] && !cs_s && sck_s && !psck[i]) begin
                    sh[i] = {sh[i][14:0], sdi_s};
                    nb[i]++;
                end
                if (cs_s && !pcs[i] && inf[i]) begin
                    inf[i] = 1'b0;
                    if (i == 0 && abort_pending && nb[i] != 16) begin
                        abort_pending = 1'b0;
                    end else begin
                        empty = (i == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
                        if (empty) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL frame_unexpected: dut %0d sent %h with no expected frame", i, sh[i]);
                        end else begin
                            expv = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                            chk($sformatf("frame_dut%0d", i), {16'(nb[i]), sh[i]}, {16'd16, expv});
                        end
                    end
                end
                pcs[i]  = cs_s;
                psck[i] = sck_s;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int          e0;
        int          bad;
        logic [15:0] pat[6];
        pat[0] = 16'hFFFF; pat[1] = 16'h0000; pat[2] = 16'hA5A5;
        pat[3] = 16'h5A5A; pat[4] = 16'h8000; pat[5] = 16'h7FFF;

        // Reset with valid held high
        a_rst = 1'b1; b_rst = 1'b1; a_valid = 1'b1; a_in = 16'h1234;
        b_valid = 1'b0; b_in = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_cs", a_cs, 1);
        chk("rst_sck", a_sck, 0);
        chk("rst_sdi", a_sdi, 0);
        chk("rst_ldac", a_ldac, 1);
        chk("rst_ready", a_ready, 1);
        chk("rst_busy", a_busy, 0);
        chk("rst_b_ready", b_ready, 1);
        a_rst = 1'b0; b_rst = 1'b0; a_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_no_frame", a_cs, 1);

        // Single sample 0xABCD -> frame 0x3ABC
        a_in = 16'hABCD; a_valid = 1'b1; exp_q0.push_back(16'h3ABC); e0 = cyc + 1;
        @(negedge clk);
        chk("e0_cs", a_cs, 0);
        chk("e0_ready", a_ready, 0);
        chk("e0_busy", a_busy, 1);
        chk("e0_sdi", a_sdi, 0);
        a_valid = 1'b0; a_in = 16'h0000;
        wait_cyc(e0 + 4);   chk("sck_rise0", a_sck, 1);
        wait_cyc(e0 + 16);  chk("sdi_bit2", a_sdi, 1);
        wait_cyc(e0 + 128); chk("hold_sck", a_sck, 0); chk("hold_sdi", a_sdi, 0); chk("hold_cs", a_cs, 0);
        wait_cyc(e0 + 131); chk("pre_latch_ldac", a_ldac, 1);
        wait_cyc(e0 + 132); chk("latch_ldac", a_ldac, 0); chk("latch_cs", a_cs, 1);
        wait_cyc(e0 + 135); chk("latch_ldac_end", a_ldac, 0);
        wait_cyc(e0 + 136); chk("post_ldac", a_ldac, 1); chk("post_ready", a_ready, 1);

        // Back-to-back 0xFFFF then 0x0000 with valid held
        repeat (3) @(negedge clk);
        a_in = 16'hFFFF; a_valid = 1'b1; e0 = cyc + 1;
        exp_q0.push_back(16'h3FFF); exp_q0.push_back(16'h3000);
        @(negedge clk);
        a_in = 16'h0000;
        wait_cyc(e0 + 131); chk("b2b_cs_low", a_cs, 0);
        wait_cyc(e0 + 132); chk("b2b_cs_rise", a_cs, 1);
        wait_cyc(e0 + 135); chk("b2b_cs_high", a_cs, 1);
        wait_cyc(e0 + 136); chk("b2b_cs_fall", a_cs, 0);
        a_valid = 1'b0;
        wait_cyc(e0 + 274); chk("b2b_idle_ready", a_ready, 1);

        // Valid held mid-frame with a changing sample
        a_in = 16'h1357; a_valid = 1'b1; exp_q0.push_back(16'h3135); e0 = cyc + 1;
        for (int k = 1; k <= 6; k++) begin
            wait_cyc(e0 + 20 * k);
            a_in = pat[k-1];
            chk("mid_ready", a_ready, 0);
        end
        wait_cyc(e0 + 134); a_in = 16'hC3A5; exp_q0.push_back(16'h3C3A);
        wait_cyc(e0 + 136); a_valid = 1'b0; a_in = 16'h0F0F;
        wait_cyc(e0 + 274); chk("mid_idle_ready", a_ready, 1);

        // Reset at E0+50 aborts the frame
        a_in = 16'h5A5A; a_valid = 1'b1; abort_pending = 1'b1; e0 = cyc + 1;
        @(negedge clk);
        a_valid = 1'b0;
        wait_cyc(e0 + 49); a_rst = 1'b1;
        @(negedge clk);
        chk("abort_cs", a_cs, 1);
        chk("abort_sck", a_sck, 0);
        chk("abort_sdi", a_sdi, 0);
        chk("abort_ldac", a_ldac, 1);
        chk("abort_ready", a_ready, 1);
        chk("abort_busy", a_busy, 0);
        a_rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (a_ldac !== 1'b1 || a_cs !== 1'b1) bad++;
        end
        chk("abort_no_ldac", bad, 0);
        chk("abort_seen", 32'(abort_pending), 0);
        a_in = 16'h2468; a_valid = 1'b1; exp_q0.push_back(16'h3246); e0 = cyc + 1;
        @(negedge clk);
        a_valid = 1'b0;
        wait_cyc(e0 + 140); chk("after_abort_ready", a_ready, 1);

        // CLKDIV=1 with 0x8001 -> frame 0x3800
        b_in = 16'h8001; b_valid = 1'b1; exp_q1.push_back(16'h3800); e0 = cyc + 1;
        @(negedge clk);
        chk("d1_cs", b_cs, 0); chk("d1_sck0", b_sck, 0); chk("d1_sdi0", b_sdi, 0);
        b_valid = 1'b0; b_in = 16'h0000;
        wait_cyc(e0 + 1);  chk("d1_sck1", b_sck, 1);
        wait_cyc(e0 + 2);  chk("d1_sck2", b_sck, 0);
        wait_cyc(e0 + 3);  chk("d1_sck3", b_sck, 1);
        wait_cyc(e0 + 32); chk("d1_hold_ready", b_ready, 0); chk("d1_hold_sck", b_sck, 0);
        wait_cyc(e0 + 33); chk("d1_latch_cs", b_cs, 1); chk("d1_latch_ldac", b_ldac, 0);
        wait_cyc(e0 + 34); chk("d1_ldac_end", b_ldac, 1); chk("d1_ready", b_ready, 1);

        repeat (5) @(negedge clk);
        chk("q0_drained", exp_q0.size(), 0);
        chk("q1_drained", exp_q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
